// File: rtl/simmem_multi_linkedlist_bank.sv
// Shared-storage bank of per-ID FIFO linked lists with round-robin release.
// Optional macro SIMMEM_LL_PER_ID_LIMIT_EN caps each list at MaxPerId entries.

module simmem_ll_id_ctx #(
  parameter int PtrW = 5,
  parameter int LenW = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PtrW-1:0] new_ptr_i,
  input  logic [PtrW-1:0] next_head_i,
  output logic [PtrW-1:0] head_o,
  output logic [PtrW-1:0] tail_o,
  output logic [LenW-1:0] len_o
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_o <= '0;
      tail_o <= '0;
      len_o  <= '0;
    end else begin
      // A push into an empty list, or one draining its last entry, makes the new slot the head.
      if (push_i && (len_o == '0 || (pop_i && len_o == LenW'(1))))
        head_o <= new_ptr_i;
      else if (pop_i)
        head_o <= next_head_i;
      if (push_i)
        tail_o <= new_ptr_i;
      if (push_i && !pop_i)
        len_o <= len_o + LenW'(1);
      else if (!push_i && pop_i)
        len_o <= len_o - LenW'(1);
    end
  end
endmodule

module simmem_multi_linkedlist_bank #(
  parameter int StructWidth   = 64,
  parameter int IDWidth       = 4,
  parameter int TotalCapacity = 32,
  parameter int MaxPerId      = 8,
  localparam int NumIds = 2 ** IDWidth,
  localparam int PtrW   = $clog2(TotalCapacity),
  localparam int LenW   = $clog2(TotalCapacity + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumIds-1:0]        release_en_i,
  input  logic [StructWidth-1:0]   data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [StructWidth-1:0]   data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [NumIds*LenW-1:0]   id_length_o,
  output logic [LenW-1:0]          free_count_o
);
  logic [TotalCapacity-1:0][StructWidth-1:0] payload;
  logic [TotalCapacity-1:0][PtrW-1:0]        next_ptr;
  logic [TotalCapacity-1:0]                  free_q;
  logic [LenW-1:0]                           free_cnt_q;
  logic [IDWidth-1:0]                        rr_ptr_q, sel_id, in_id;
  logic [NumIds-1:0][PtrW-1:0]               head, tail;
  logic [NumIds-1:0][LenW-1:0]               len;
  logic [NumIds-1:0]                         push, pop, elig;
  logic [PtrW-1:0]                           alloc_ptr;
  logic [StructWidth-1:0]                    out_word;
  logic                                      in_hs, out_hs;

  assign in_id        = data_i[IDWidth-1:0];
  assign free_count_o = free_cnt_q;
  assign in_hs        = in_valid_i && in_ready_o;
  assign out_hs       = out_valid_o && out_ready_i;

`ifdef SIMMEM_LL_PER_ID_LIMIT_EN
  assign in_ready_o = (free_cnt_q != '0) && (len[in_id] != LenW'(MaxPerId));
`else
  logic unused_max_per_id;
  assign unused_max_per_id = ^MaxPerId;
  assign in_ready_o = (free_cnt_q != '0);
`endif

  for (genvar g = 0; g < NumIds; g++) begin : g_id
    assign elig[g] = (len[g] != '0) && release_en_i[g];
    assign push[g] = in_hs && (in_id == IDWidth'(g));
    assign pop[g]  = out_hs && (sel_id == IDWidth'(g));
    assign id_length_o[g*LenW +: LenW] = len[g];

    simmem_ll_id_ctx #(.PtrW(PtrW), .LenW(LenW)) u_ctx (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push[g]),
      .pop_i       (pop[g]),
      .new_ptr_i   (alloc_ptr),
      .next_head_i (next_ptr[head[g]]),
      .head_o      (head[g]),
      .tail_o      (tail[g]),
      .len_o       (len[g])
    );
  end

  // Round-robin search starts just after the last released ID.
  always_comb begin
    logic [IDWidth-1:0] cand;
    out_valid_o = 1'b0;
    sel_id      = '0;
    cand        = '0;
    for (int i = 1; i <= NumIds; i++) begin
      cand = rr_ptr_q + IDWidth'(i);
      if (!out_valid_o && elig[cand]) begin
        out_valid_o = 1'b1;
        sel_id      = cand;
      end
    end
  end

  always_comb begin
    out_word = payload[head[sel_id]];
    out_word[IDWidth-1:0] = sel_id;
    data_o = out_valid_o ? out_word : '0;
  end

  // Allocation reads the registered bitmap, so a slot freed this cycle waits a cycle.
  always_comb begin
    alloc_ptr = '0;
    for (int i = TotalCapacity - 1; i >= 0; i--)
      if (free_q[i]) alloc_ptr = PtrW'(i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      free_q     <= '1;
      free_cnt_q <= LenW'(TotalCapacity);
      rr_ptr_q   <= '1;
    end else begin
      if (in_hs)  free_q[alloc_ptr]    <= 1'b0;
      if (out_hs) free_q[head[sel_id]] <= 1'b1;
      if (in_hs && !out_hs)
        free_cnt_q <= free_cnt_q - LenW'(1);
      else if (!in_hs && out_hs)
        free_cnt_q <= free_cnt_q + LenW'(1);
      if (out_hs) rr_ptr_q <= sel_id;
    end
  end

  // Link to the old tail only when the list is non-empty; an empty list's tail is stale.
  always_ff @(posedge clk_i) begin
    if (in_hs) begin
      payload[alloc_ptr] <= data_i;
      if (len[in_id] != '0)
        next_ptr[tail[in_id]] <= alloc_ptr;
    end
  end
endmodule

// File: tb/tb_simmem_multi_linkedlist_bank.sv
// Bench for simmem_multi_linkedlist_bank: directed table, corner sequences, random vs queue model.

module tb_simmem_multi_linkedlist_bank;
  localparam int SW = 16, IDW = 2, TC = 4, MPI = 2, NI = 4, LW = 3;

  logic          clk = 1'b0, rst = 1'b1;
  logic [NI-1:0] rel = '0;
  logic [SW-1:0] din = '0, dout;
  logic          iv = 1'b0, irdy, ov, ordy = 1'b0;
  logic [NI*LW-1:0] idlen;
  logic [LW-1:0] fcnt;

  simmem_multi_linkedlist_bank #(
    .StructWidth(SW), .IDWidth(IDW), .TotalCapacity(TC), .MaxPerId(MPI)
  ) dut (
    .clk_i(clk), .rst_i(rst), .release_en_i(rel), .data_i(din),
    .in_valid_i(iv), .in_ready_o(irdy), .data_o(dout), .out_valid_o(ov),
    .out_ready_i(ordy), .id_length_o(idlen), .free_count_o(fcnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: one queue per ID plus the last released ID.
  logic [SW-1:0] mq [NI][$];
  int            rr = NI - 1;
  logic          m_ov, m_rdy, m_ihs, m_ohs;
  int            m_id;
  logic [SW-1:0] m_data;
  logic [LW-1:0] m_free;
  logic [NI*LW-1:0] m_len;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) mq[k].delete();
    rr = NI - 1;
  endtask

  task automatic model_eval();
    int total = 0;
    int id;
    m_len = '0;
    for (int k = 0; k < NI; k++) begin
      total += mq[k].size();
      m_len[k*LW +: LW] = LW'(mq[k].size());
    end
    m_free = LW'(TC - total);
    m_rdy  = (total < TC);
`ifdef SIMMEM_LL_PER_ID_LIMIT_EN
    if (mq[din[IDW-1:0]].size() == MPI) m_rdy = 1'b0;
`endif
    m_ov = 1'b0; m_id = 0; m_data = '0;
    for (int i = 1; i <= NI; i++) begin
      id = (rr + i) % NI;
      if (!m_ov && mq[id].size() > 0 && rel[id]) begin
        m_ov = 1'b1; m_id = id; m_data = mq[id][0];
      end
    end
    m_ihs = iv && m_rdy;
    m_ohs = m_ov && ordy;
  endtask

  // Drive inputs, let them settle, then compare every output with the model.
  task automatic apply(input logic v, input logic [SW-1:0] d, input logic [NI-1:0] r, input logic o);
    iv = v; din = d; rel = r; ordy = o;
    #1;
    model_eval();
    chk("out_valid", ov, m_ov);
    chk("data_o", dout, m_data);
    chk("in_ready", irdy, m_rdy);
    chk("free_count", fcnt, m_free);
    chk("id_length", idlen, m_len);
  endtask

  task automatic commit();
    logic [SW-1:0] d;
    d = din;
    @(posedge clk);
    if (m_ohs) begin
      void'(mq[m_id].pop_front());
      rr = m_id;
    end
    if (m_ihs) mq[d[IDW-1:0]].push_back(d);
    @(negedge clk);
  endtask

  typedef struct {
    logic iv; logic [SW-1:0] d; logic [NI-1:0] rel; logic ordy;
    logic ov; logic [SW-1:0] dout; logic [LW-1:0] free; logic rdy; logic [LW-1:0] len1;
  } vec_t;
  vec_t tv[8];

  logic [SW-1:0] rr_exp [4];

  initial begin
    tv[0] = '{1'b1, 16'hAA01, 4'b0000, 1'b0, 1'b0, 16'h0000, 3'd4, 1'b1, 3'd0};
    tv[1] = '{1'b1, 16'hBB01, 4'b0000, 1'b0, 1'b0, 16'h0000, 3'd3, 1'b1, 3'd1};
    tv[2] = '{1'b1, 16'hCC02, 4'b0000, 1'b0, 1'b0, 16'h0000, 3'd2, 1'b1, 3'd2};
    tv[3] = '{1'b1, 16'hDD03, 4'b0000, 1'b0, 1'b0, 16'h0000, 3'd1, 1'b1, 3'd2};
    tv[4] = '{1'b1, 16'hEE00, 4'b0000, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 3'd2};
    tv[5] = '{1'b0, 16'h0000, 4'b0010, 1'b1, 1'b1, 16'hAA01, 3'd0, 1'b0, 3'd2};
    tv[6] = '{1'b0, 16'h0000, 4'b0010, 1'b1, 1'b1, 16'hBB01, 3'd1, 1'b1, 3'd1};
    tv[7] = '{1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 16'h0000, 3'd2, 1'b1, 3'd0};
    rr_exp = '{16'h1101, 16'h2202, 16'h3303, 16'h4401};

    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", irdy, 1'b1);
    chk("rst_out_valid", ov, 1'b0);
    chk("rst_data", dout, 16'h0);
    chk("rst_free", fcnt, 3'd4);
    chk("rst_len", idlen, 12'h0);
    @(negedge clk);

    // Fill, refuse, then per-ID ordered drain.
    for (int i = 0; i < 8; i++) begin
      apply(tv[i].iv, tv[i].d, tv[i].rel, tv[i].ordy);
      chk("tbl_ov", ov, tv[i].ov);
      chk("tbl_dout", dout, tv[i].dout);
      chk("tbl_free", fcnt, tv[i].free);
      chk("tbl_rdy", irdy, tv[i].rdy);
      chk("tbl_len1", idlen[LW +: LW], tv[i].len1);
      commit();
    end

    // Reset mid-operation with a write presented during reset.
    apply(1'b1, 16'h0100, 4'b0000, 1'b0); commit();
    chk("pre_rst_free", fcnt, 3'd1);
    rst = 1'b1; iv = 1'b1; din = 16'h0201; rel = 4'b1111; ordy = 1'b1;
    #1;
    chk("midrst_ov", ov, 1'b0);
    chk("midrst_free", fcnt, 3'd4);
    chk("midrst_len", idlen, 12'h0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    apply(1'b0, 16'h0, 4'b1111, 1'b0);
    chk("postrst_free", fcnt, 3'd4);
    commit();

    // Round-robin across IDs 1..3.
    for (int i = 0; i < 4; i++) begin apply(1'b1, rr_exp[i], 4'b0000, 1'b0); commit(); end
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 16'h0, 4'b1110, 1'b1);
      chk("rr_order", dout, rr_exp[i]);
      commit();
    end

    // Simultaneous push and release on the same single-entry list.
    apply(1'b1, 16'h1101, 4'b0000, 1'b0); commit();
    apply(1'b1, 16'h2201, 4'b0010, 1'b1);
    chk("same_id_out", dout, 16'h1101);
    commit();
    apply(1'b0, 16'h0, 4'b0010, 1'b0);
    chk("same_id_len", idlen[LW +: LW], 3'd1);
    chk("same_id_next", dout, 16'h2201);
    commit();
    apply(1'b0, 16'h0, 4'b0010, 1'b1); commit();

    // Per-ID limit: third ID1 write with one slot still free.
    apply(1'b1, 16'h0101, 4'b0000, 1'b0); commit();
    apply(1'b1, 16'h0201, 4'b0000, 1'b0); commit();
    apply(1'b1, 16'h0000, 4'b0000, 1'b0); commit();
    apply(1'b1, 16'h0301, 4'b0000, 1'b0);
    chk("limit_free", fcnt, 3'd1);
`ifdef SIMMEM_LL_PER_ID_LIMIT_EN
    chk("limit_rdy", irdy, 1'b0);
`else
    chk("limit_rdy", irdy, 1'b1);
`endif
    commit();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      commit();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
